// File: rtl/reduction_byte_serializer.sv
// Byte-lane serializer: captures an A/B register pair and streams its four byte lanes over valid/ready,
// accumulating the lane sum. Optional parity output and latch guard under REDUCTION_SERIAL_PARITY_EN.
module reduction_byte_serializer #(
  parameter int ORDER     = 0,
  parameter int HOLD_LAST = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic [1:0]  out_idx,
  output logic        out_last,
  output logic        busy,
  output logic [15:0] sum,
  output logic        sum_valid
`ifdef REDUCTION_SERIAL_PARITY_EN
  ,
  output logic        out_parity
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [1:0]  idx_q, idx_d;
  logic [9:0]  sum_q, sum_d;
  logic        sum_valid_q, sum_valid_d;
  logic [7:0]  last_q, last_d;
  logic [7:0]  lane;
  logic        ovr_q, ovr_d;

  function automatic logic [7:0] sel_lane(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] idx);
    logic [7:0] r;
    if (ORDER == 0) begin
      case (idx)
        2'd0:    r = a[7:0];
        2'd1:    r = b[7:0];
        2'd2:    r = a[15:8];
        default: r = b[15:8];
      endcase
    end else begin
      case (idx)
        2'd0:    r = a[7:0];
        2'd1:    r = a[15:8];
        2'd2:    r = b[7:0];
        default: r = b[15:8];
      endcase
    end
    return r;
  endfunction

  always_comb lane = sel_lane(a_q, b_q, idx_q);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    last_d      = last_q;
    sum_valid_d = 1'b0;
    ovr_d       = ovr_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          sum_d   = '0;
          idx_d   = 2'd0;
          ovr_d   = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        // A write into the operand latch mid-pair would corrupt the sum; the FSM never allows it.
        if (in_valid && in_ready) ovr_d = 1'b1;
        if (out_ready) begin
          sum_d  = sum_q + {2'b00, lane};
          last_d = lane;
          if (idx_q == 2'd3) begin
            state_d = IDLE;
`ifdef REDUCTION_SERIAL_PARITY_EN
            sum_valid_d = !ovr_q;
`else
            sum_valid_d = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      last_q      <= '0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      last_q      <= last_d;
      ovr_q       <= ovr_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SEND);
  assign out_valid = (state_q == SEND);
  assign out_idx   = (state_q == SEND) ? idx_q : 2'd0;
  assign out_last  = (state_q == SEND) && (idx_q == 2'd3);
  assign out_byte  = (state_q == SEND) ? lane : ((HOLD_LAST != 0) ? last_q : 8'h00);
  assign sum       = {6'b0, sum_q};
  assign sum_valid = sum_valid_q;

`ifdef REDUCTION_SERIAL_PARITY_EN
  assign out_parity = out_valid ? ^out_byte : 1'b0;
`endif

endmodule

// File: tb/tb_reduction_byte_serializer.sv
// Scoreboard bench for reduction_byte_serializer: two instances (ORDER=0/HOLD_LAST=0 and ORDER=1/HOLD_LAST=1)
// share stimulus; a negedge monitor pops hand-computed lanes and sums as the DUTs present them.
module tb_reduction_byte_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready;
  logic [15:0] A, B;
  logic        ir [2];
  logic        ov [2];
  logic        ol [2];
  logic        bz [2];
  logic        sv [2];
  logic [7:0]  ob [2];
  logic [1:0]  oi [2];
  logic [15:0] sm [2];
`ifdef REDUCTION_SERIAL_PARITY_EN
  logic        op [2];
`endif

  reduction_byte_serializer #(.ORDER(0), .HOLD_LAST(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .A(A), .B(B),
    .out_valid(ov[0]), .out_ready(out_ready), .out_byte(ob[0]), .out_idx(oi[0]),
    .out_last(ol[0]), .busy(bz[0]), .sum(sm[0]), .sum_valid(sv[0])
`ifdef REDUCTION_SERIAL_PARITY_EN
    , .out_parity(op[0])
`endif
  );

  reduction_byte_serializer #(.ORDER(1), .HOLD_LAST(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .A(A), .B(B),
    .out_valid(ov[1]), .out_ready(out_ready), .out_byte(ob[1]), .out_idx(oi[1]),
    .out_last(ol[1]), .busy(bz[1]), .sum(sm[1]), .sum_valid(sv[1])
`ifdef REDUCTION_SERIAL_PARITY_EN
    , .out_parity(op[1])
`endif
  );

  typedef struct packed {
    logic [7:0] b;
    logic [1:0] i;
    logic       l;
  } exp_t;

  exp_t        eq [2][$];
  logic [15:0] sq [2][$];
  int          errors = 0;
  int          checks = 0;
  int          done0  = 0;
  logic [7:0]  last_b [2];
  logic        held_v [2];
  logic [7:0]  held_b [2];
  logic [1:0]  held_i [2];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Bytes packed with idx0 in [31:24]; n<4 pushes a truncated pair with no sum.
  task automatic push(input logic [31:0] e0, input logic [31:0] e1, input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      eq[0].push_back('{b: e0[31-8*i -: 8], i: i[1:0], l: (i == 3)});
      eq[1].push_back('{b: e1[31-8*i -: 8], i: i[1:0], l: (i == 3)});
    end
    if (n == 4) begin
      sq[0].push_back(s);
      sq[1].push_back(s);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        last_b[k] = 8'h00;
        held_v[k] = 1'b0;
      end else begin
        chk($sformatf("in_ready_vs_valid%0d", k), ir[k], !ov[k]);
        if (held_v[k] && ov[k]) begin
          chk($sformatf("stall_byte%0d", k), ob[k], held_b[k]);
          chk($sformatf("stall_idx%0d", k), oi[k], held_i[k]);
        end
        held_v[k] = ov[k] && !out_ready;
        held_b[k] = ob[k];
        held_i[k] = oi[k];
        if (!ov[k])
          chk($sformatf("idle_byte%0d", k), ob[k], (k == 1) ? last_b[k] : 8'h00);
        if (ov[k] && out_ready) begin
          if (eq[k].size() == 0) begin
            fail_now($sformatf("unexpected_xfer%0d byte=%h", k, ob[k]));
          end else begin
            e = eq[k].pop_front();
            chk($sformatf("byte%0d", k), ob[k], e.b);
            chk($sformatf("idx%0d", k), oi[k], e.i);
            chk($sformatf("last%0d", k), ol[k], e.l);
            last_b[k] = e.b;
`ifdef REDUCTION_SERIAL_PARITY_EN
            chk($sformatf("parity%0d", k), op[k], ^e.b);
`endif
          end
        end
`ifdef REDUCTION_SERIAL_PARITY_EN
        if (!ov[k]) chk($sformatf("parity_idle%0d", k), op[k], 1'b0);
`endif
        if (sv[k]) begin
          if (sq[k].size() == 0) fail_now($sformatf("unexpected_sum_valid%0d sum=%h", k, sm[k]));
          else chk($sformatf("sum%0d", k), sm[k], sq[k].pop_front());
          if (k == 0) done0++;
        end
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    int c = 0;
    @(negedge clk);
    while (!ir[0] && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (!ir[0]) fail_now("issue_timeout");
    in_valid = 1'b1;
    A = a;
    B = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit stall);
    int         start = done0;
    logic [3:0] pat = 4'b1001;
    for (int c = 0; c < 80 && done0 == start; c++) begin
      @(posedge clk);
      #1;
      if (stall) out_ready = pat[c % 4];
    end
    out_ready = 1'b1;
    if (done0 == start) fail_now("sum_valid_timeout");
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; A = 16'h1234; B = 16'hABCD; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", ov[0], 1'b0);
    chk("rst_busy", bz[0], 1'b0);
    chk("rst_sum", sm[0], 16'h0000);
    chk("rst_sum_valid", sv[0], 1'b0);
    chk("rst_out_byte", ob[1], 8'h00);
    chk("rst_out_idx", oi[0], 2'd0);
    chk("rst_out_last", ol[0], 1'b0);
    chk("rst_in_ready", ir[0], 1'b1);
    @(negedge clk);
    chk("no_capture_in_reset", ov[0], 1'b0);

    push(32'h34CD12AB, 32'h3412CDAB, 16'h01BE, 4);
    issue(16'h1234, 16'hABCD);
    wait_done(1'b0);

    push(32'hFFFFFFFF, 32'hFFFFFFFF, 16'h03FC, 4);
    issue(16'hFFFF, 16'hFFFF);
    wait_done(1'b1);

    // in_valid stays high; operands change mid-pair and must only land on the next IDLE capture.
    push(32'h01020000, 32'h01000200, 16'h0003, 4);
    push(32'h00000100, 32'h00010000, 16'h0001, 4);
    @(negedge clk);
    in_valid = 1'b1; A = 16'h0001; B = 16'h0002;
    @(posedge clk);
    #1 A = 16'h0100; B = 16'h0000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("in_ready_send", ir[0], 1'b0);
      chk("busy_send", bz[1], 1'b1);
    end
    wait_done(1'b0);
    in_valid = 1'b0;
    wait_done(1'b0);

    push(32'h03000700, 32'h03070000, 16'h000A, 4);
    issue(16'h0703, 16'h0000);
    wait_done(1'b0);

    push(32'hFFFF0000, 32'hFF00FF00, 16'h0000, 2);
    @(negedge clk);
    in_valid = 1'b1; A = 16'h00FF; B = 16'h00FF;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", ov[0], 1'b0);
    chk("abort_sum", sm[0], 16'h0000);
    chk("abort_sum_valid", sv[0], 1'b0);
    chk("abort_in_ready", ir[1], 1'b1);
    repeat (4) @(negedge clk);
    chk("queues_drained", 16'(eq[0].size() + eq[1].size() + sq[0].size() + sq[1].size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
